// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one in-order pipelined divider between NUM_REQ requesters.
// Requests are granted combinationally. A tag FIFO remembers each issued request's
// owner, so every quotient is sent back to the requester that issued it.
module div_share_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned DIVIDEND_WIDTH  = 16,
  parameter int unsigned DIVISOR_WIDTH   = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic [DIVIDEND_WIDTH-1:0]           resp_quotient,
  output logic                                div_valid_in,
  output logic [DIVIDEND_WIDTH-1:0]           div_dividend,
  output logic [DIVISOR_WIDTH-1:0]            div_divisor,
  input  logic                                div_valid_out,
  input  logic [DIVIDEND_WIDTH-1:0]           div_quotient,
  output logic                                busy,
  output logic                                err_orphan
);

  localparam int unsigned TagW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

  logic [TagW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [TagW-1:0]           tag_mem_q [MAX_OUTSTANDING];
  logic                      div_valid_in_q;
  logic [DIVIDEND_WIDTH-1:0] div_dividend_q;
  logic [DIVISOR_WIDTH-1:0]  div_divisor_q;
  logic [NUM_REQ-1:0]        resp_valid_q, resp_valid_d;
  logic [DIVIDEND_WIDTH-1:0] resp_quotient_q;
  logic                      err_orphan_q;

  logic [NUM_REQ-1:0]        grant;
  logic [TagW-1:0]           grant_idx;
  logic                      found;
  logic                      full;
  logic                      accept;
  logic                      pop;
  logic                      orphan;
  logic [DIVIDEND_WIDTH-1:0] sel_dividend;
  logic [DIVISOR_WIDTH-1:0]  sel_divisor;

  // A pop in the same cycle does not free a slot: fullness uses the registered count only.
  assign full   = (count_q == CntW'(MAX_OUTSTANDING));
  assign accept = |grant;
  assign pop    = div_valid_out && (count_q != '0);
  assign orphan = div_valid_out && (count_q == '0);

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ; grant is one-hot or zero.
  always_comb begin
    int unsigned idx;
    logic [TagW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = TagW'(idx);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found && !full && !reset) grant[grant_idx] = 1'b1;
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        sel_dividend = req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        sel_divisor  = req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
      end
    end
  end

  // Next-state for pointer, occupancy and response routing.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == TagW'(NUM_REQ - 1)) ? '0 : grant_idx + TagW'(1);
    end
    count_d = count_q;
    if (accept && !pop) count_d = count_q + CntW'(1);
    if (!accept && pop) count_d = count_q - CntW'(1);
    resp_valid_d = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      resp_valid_d[i] = pop && (tag_mem_q[rd_ptr_q] == TagW'(i));
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q        <= '0;
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      div_valid_in_q  <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      resp_valid_q    <= '0;
      resp_quotient_q <= '0;
      err_orphan_q    <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      count_q        <= count_d;
      div_valid_in_q <= accept;
      resp_valid_q   <= resp_valid_d;
      if (accept) begin
        wr_ptr_q       <= wr_ptr_q + PtrW'(1);
        div_dividend_q <= sel_dividend;
        div_divisor_q  <= sel_divisor;
      end
      if (pop) begin
        rd_ptr_q        <= rd_ptr_q + PtrW'(1);
        resp_quotient_q <= div_quotient;
      end
      if (orphan) err_orphan_q <= 1'b1;
    end
  end

  // Tag storage; contents are only read while count is non-zero, so no reset is needed.
  always_ff @(posedge clock) begin
    if (!reset && accept) tag_mem_q[wr_ptr_q] <= grant_idx;
  end

  assign req_ready     = grant;
  assign resp_valid    = resp_valid_q;
  assign resp_quotient = resp_quotient_q;
  assign div_valid_in  = div_valid_in_q;
  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign busy          = (count_q != '0);
  assign err_orphan    = err_orphan_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a fixed-latency stub divider.
module tb_div_share_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] dvd0, dvd1;
  logic [7:0]  dvs0, dvs1;
  logic [31:0] req_dividend;
  logic [15:0] req_divisor;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [15:0] resp_quotient;
  logic        div_valid_in;
  logic [15:0] div_dividend;
  logic [7:0]  div_divisor;
  logic        div_valid_out;
  logic [15:0] div_quotient;
  logic        busy;
  logic        err_orphan;

  int vectors = 0;
  int errors  = 0;

  // Stub divider: result appears lat_m1+1 cycles after div_valid_in.
  logic [3:0]  lat_m1 = 4'd2;
  logic [15:0] pv;
  logic [15:0] pq [16];
  logic        force_v;
  logic [15:0] force_q;
  logic [15:0] stub_q;

  assign req_dividend  = {dvd1, dvd0};
  assign req_divisor   = {dvs1, dvs0};
  assign stub_q        = (div_divisor == 8'd0) ? 16'hFFFF : div_dividend / {8'd0, div_divisor};
  assign div_valid_out = pv[lat_m1] | force_v;
  assign div_quotient  = force_v ? force_q : pq[lat_m1];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv    <= {pv[14:0], div_valid_in};
      pq[0] <= stub_q;
      for (int i = 1; i < 16; i++) pq[i] <= pq[i-1];
    end
  end

  div_share_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_quotient(resp_quotient),
    .div_valid_in (div_valid_in),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_valid_out(div_valid_out),
    .div_quotient (div_quotient),
    .busy         (busy),
    .err_orphan   (err_orphan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset with both requesters asserting valid; every output must read zero.
  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 2'b11;
    force_v   = 1'b0;
    tick();
    #1;
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst resp_valid", 32'(resp_valid), 0);
    chk("rst div_valid_in", 32'(div_valid_in), 0);
    chk("rst div_dividend", 32'(div_dividend), 0);
    chk("rst div_divisor", 32'(div_divisor), 0);
    chk("rst resp_quotient", 32'(resp_quotient), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst err_orphan", 32'(err_orphan), 0);
    reset     = 1'b0;
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; force_v = 1'b0; force_q = '0;
    dvd0 = '0; dvd1 = '0; dvs0 = '0; dvs1 = '0;

    // Single request, latency 3.
    lat_m1 = 4'd2;
    do_reset();
    req_valid = 2'b01; dvd0 = 16'd2385; dvs0 = 8'd159;
    #1; chk("s1 ready T", 32'(req_ready), 1);
    tick(); req_valid = 2'b00;
    #1; chk("s1 valid_in T+1", 32'(div_valid_in), 1);
    chk("s1 dividend T+1", 32'(div_dividend), 2385);
    chk("s1 divisor T+1", 32'(div_divisor), 159);
    chk("s1 busy T+1", 32'(busy), 1);
    tick(); #1; chk("s1 valid_in T+2", 32'(div_valid_in), 0);
    tick(); tick(); #1; chk("s1 resp early T+4", 32'(resp_valid), 0);
    tick(); #1; chk("s1 resp T+5", 32'(resp_valid), 1);
    chk("s1 quotient T+5", 32'(resp_quotient), 15);
    chk("s1 busy T+5", 32'(busy), 0);
    tick(); #1; chk("s1 resp T+6", 32'(resp_valid), 0);
    chk("s1 quotient hold", 32'(resp_quotient), 15);

    // Both requesting: alternate grants until the tag FIFO fills.
    do_reset();
    dvd0 = 16'd100; dvs0 = 8'd5; dvd1 = 16'd200; dvs1 = 8'd8; req_valid = 2'b11;
    #1; chk("s2 grant c0", 32'(req_ready), 1);
    tick(); #1; chk("s2 grant c1", 32'(req_ready), 2);
    chk("s2 dividend c1", 32'(div_dividend), 100);
    tick(); #1; chk("s2 grant c2", 32'(req_ready), 1);
    chk("s2 dividend c2", 32'(div_dividend), 200);
    tick(); #1; chk("s2 grant c3", 32'(req_ready), 2);
    tick(); #1; chk("s2 full c4", 32'(req_ready), 0);
    chk("s2 busy c4", 32'(busy), 1);
    tick(); req_valid = 2'b00;
    #1; chk("s2 resp c5", 32'(resp_valid), 1); chk("s2 q c5", 32'(resp_quotient), 20);
    tick(); #1; chk("s2 resp c6", 32'(resp_valid), 2); chk("s2 q c6", 32'(resp_quotient), 25);
    tick(); #1; chk("s2 resp c7", 32'(resp_valid), 1); chk("s2 q c7", 32'(resp_quotient), 20);
    tick(); #1; chk("s2 resp c8", 32'(resp_valid), 2); chk("s2 q c8", 32'(resp_quotient), 25);
    chk("s2 busy c8", 32'(busy), 0);

    // Routing: req1 then req0, latency 2.
    lat_m1 = 4'd1;
    do_reset();
    req_valid = 2'b10; dvd1 = 16'd100; dvs1 = 8'd10;
    #1; chk("s5 grant req1", 32'(req_ready), 2);
    tick(); req_valid = 2'b01; dvd0 = 16'd90; dvs0 = 8'd9;
    #1; chk("s5 grant req0", 32'(req_ready), 1);
    chk("s5 dividend 1", 32'(div_dividend), 100);
    chk("s5 divisor 1", 32'(div_divisor), 10);
    tick(); req_valid = 2'b00;
    #1; chk("s5 valid_in 2", 32'(div_valid_in), 1);
    chk("s5 dividend 2", 32'(div_dividend), 90);
    chk("s5 divisor 2", 32'(div_divisor), 9);
    tick(); tick(); #1; chk("s5 resp first", 32'(resp_valid), 2);
    chk("s5 q first", 32'(resp_quotient), 10);
    tick(); #1; chk("s5 resp second", 32'(resp_valid), 1);
    chk("s5 q second", 32'(resp_quotient), 10);
    tick(); #1; chk("s5 resp idle", 32'(resp_valid), 0);

    // Orphan result with nothing in flight.
    do_reset();
    force_v = 1'b1; force_q = 16'd1234;
    tick(); force_v = 1'b0;
    #1; chk("s4 orphan set", 32'(err_orphan), 1);
    chk("s4 no resp", 32'(resp_valid), 0);
    chk("s4 busy", 32'(busy), 0);
    tick(); tick(); #1; chk("s4 orphan sticky", 32'(err_orphan), 1);
    chk("s4 quotient untouched", 32'(resp_quotient), 0);

    // Divisor 0 passes through unchanged (reset also clears the orphan flag).
    lat_m1 = 4'd2;
    do_reset();
    req_valid = 2'b01; dvd0 = 16'd500; dvs0 = 8'd0;
    #1; chk("dz grant", 32'(req_ready), 1);
    tick(); req_valid = 2'b00;
    #1; chk("dz divisor", 32'(div_divisor), 0);
    chk("dz dividend", 32'(div_dividend), 500);
    tick(); tick(); tick(); tick();
    #1; chk("dz resp", 32'(resp_valid), 1);
    chk("dz quotient", 32'(resp_quotient), 16'hFFFF);

    // Full: latency 10, req0 always valid.
    lat_m1 = 4'd9;
    do_reset();
    req_valid = 2'b01; dvd0 = 16'd50; dvs0 = 8'd7;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("s3 ready c%0d", c), 32'(req_ready), (c < 4) ? 1 : 0);
      chk($sformatf("s3 busy c%0d", c), 32'(busy), (c > 0) ? 1 : 0);
      tick();
    end
    #1; chk("s3 ready back c12", 32'(req_ready), 1);
    chk("s3 busy c12", 32'(busy), 1);
    tick(); req_valid = 2'b00;
    #1; chk("s3 busy c13", 32'(busy), 1);

    // Reset with divisions in flight, then both request.
    do_reset();
    req_valid = 2'b11;
    #1; chk("s6 first grant", 32'(req_ready), 1);
    tick(); req_valid = 2'b00;
    tick(); tick(); tick(); tick(); tick();
    #1; chk("s6 no orphan", 32'(err_orphan), 0);
    chk("s6 resp_valid", 32'(resp_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
